// File: rtl/count_sequencer.sv
// Programmable timer sequencer: prescaled up-counter with start/stop/pause,
// a terminal count, and one-shot or auto-reload operation.
module count_sequencer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  mode_reload,
  input  logic [WIDTH-1:0]      term_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      cout,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = 1;
  localparam logic [PRESCALE_W-1:0] PSC_ONE = 1;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      cout_q, cout_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]      term_q, term_d;
  logic [PRESCALE_W-1:0] psc_s_q, psc_s_d;
  logic                  reload_q, reload_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  en;
  logic [WIDTH-1:0]      cout_inc;

  assign en       = (state_q == S_RUN) && !pause && !stop && (psc_q == psc_s_q);
  assign cout_inc = cout_q + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cout_q   <= '0;
      psc_q    <= '0;
      term_q   <= '0;
      psc_s_q  <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cout_q   <= cout_d;
      psc_q    <= psc_d;
      term_q   <= term_d;
      psc_s_q  <= psc_s_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cout_d   = cout_q;
    psc_d    = psc_q;
    term_d   = term_q;
    psc_s_d  = psc_s_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          cout_d  = '0;
          psc_d   = '0;
        end else if (start) begin
          term_d   = term_val;
          psc_s_d  = prescale;
          reload_d = mode_reload;
          cout_d   = '0;
          psc_d    = '0;
          // A zero terminal count completes on the start edge itself
          if (term_val == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          cout_d  = '0;
          psc_d   = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (en) begin
          psc_d = '0;
          if (cout_inc == term_q) begin
            done_d = 1'b1;
            if (reload_q) begin
              cout_d = '0;
            end else begin
              cout_d  = term_q;
              state_d = S_DONE;
            end
          end else begin
            cout_d = cout_inc;
          end
        end else begin
          psc_d = psc_q + PSC_ONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          cout_d  = '0;
          psc_d   = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  assign cout  = cout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with hand-computed expectations.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode_reload = 1'b0;
  logic [3:0] term_val = '0;
  logic [3:0] prescale = '0;
  logic [3:0] cout;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  count_sequencer #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode_reload(mode_reload), .term_val(term_val), .prescale(prescale),
    .cout(cout), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input int c, input int s, input int b, input int d);
    check({tag, ".cout"}, int'(cout), c);
    check({tag, ".state"}, int'(state), s);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".done"}, int'(done), d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int tv, input int ps, input logic rl);
    term_val    = 4'(tv);
    prescale    = 4'(ps);
    mode_reload = rl;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    #2 expect_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #4;

    // one-shot, term 5, no prescale
    launch(5, 0, 1'b0);
    expect_all("t1.e0", 0, 1, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t1.cout%0d", i), int'(cout), i);
      check($sformatf("t1.done%0d", i), int'(done), (i == 5) ? 1 : 0);
    end
    check("t1.state", int'(state), 3);
    check("t1.busy", int'(busy), 0);
    tick();
    expect_all("t1.hold", 5, 3, 0, 0);

    // restart from DONE: term 2, prescale 2
    launch(2, 2, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("t2.cout%0d", i), int'(cout), i / 3);
      check($sformatf("t2.done%0d", i), int'(done), (i == 6) ? 1 : 0);
    end
    check("t2.state", int'(state), 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_all("t2.stop_done", 0, 0, 0, 0);

    // auto-reload, term 3
    launch(3, 0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("t3.cout%0d", i), int'(cout), i % 3);
      check($sformatf("t3.done%0d", i), int'(done), (i % 3 == 0) ? 1 : 0);
      check($sformatf("t3.state%0d", i), int'(state), 1);
      check($sformatf("t3.busy%0d", i), int'(busy), 1);
    end
    tick();
    check("t3.cout7", int'(cout), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_all("t3.stop", 0, 0, 0, 0);

    // pause for four edges after cout reaches 2
    launch(6, 0, 1'b0);
    tick();
    tick();
    check("t4.pre", int'(cout), 2);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_all($sformatf("t4.p%0d", i), 2, 2, 1, 0);
    end
    pause = 1'b0;
    tick();
    expect_all("t4.resume", 2, 1, 1, 0);
    for (int i = 3; i <= 6; i++) begin
      tick();
      check($sformatf("t4.cout%0d", i), int'(cout), i);
      check($sformatf("t4.done%0d", i), int'(done), (i == 6) ? 1 : 0);
    end
    check("t4.state", int'(state), 3);

    // pause and stop together win as stop
    launch(6, 0, 1'b0);
    tick();
    pause = 1'b1;
    stop  = 1'b1;
    tick();
    pause = 1'b0;
    stop  = 1'b0;
    expect_all("t4.pstop", 0, 0, 0, 0);

    // asynchronous reset mid-run
    launch(8, 0, 1'b0);
    tick();
    tick();
    tick();
    check("t5.pre", int'(cout), 3);
    #2 reset = 1'b0;
    #1 expect_all("t5.async", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #4;
    launch(2, 0, 1'b0);
    tick();
    check("t5.c1", int'(cout), 1);
    tick();
    expect_all("t5.end", 2, 3, 0, 1);

    // zero terminal count, then start ignored in RUN
    launch(0, 0, 1'b0);
    expect_all("t6.zero", 0, 3, 0, 1);
    tick();
    check("t6.zero_pulse", int'(done), 0);
    launch(4, 0, 1'b0);
    start       = 1'b1;
    term_val    = 4'd2;
    mode_reload = 1'b1;
    tick();
    start = 1'b0;
    expect_all("t6.ign", 1, 1, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("t6.cout%0d", i), int'(cout), i);
      check($sformatf("t6.done%0d", i), int'(done), (i == 4) ? 1 : 0);
    end
    check("t6.state", int'(state), 3);
    tick();
    expect_all("t6.hold", 4, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
